// File: rtl/if_fetch_queue.sv
// ============================================================================
// Module   : if_fetch_queue
// Brief    : IF-stage PC register plus in-order fetch queue feeding ID.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_queue #(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 64'h0000_0000_8000_0000,
    parameter int                  FQ_DEPTH    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [PC_WIDTH-1:0]    IF_pc_o,
    input  logic [PC_WIDTH-1:0]    ifu_pc_next_i,
    input  logic [INSTR_WIDTH-1:0] ifu_instr_i,
    input  logic                   ifu_prdt_taken_i,
    input  logic                   ifu_pc_misalign_i,
    input  logic                   ifu_bus_err_i,
    input  logic                   flush_i,
    input  logic [PC_WIDTH-1:0]    flush_pc_i,
    input  logic                   id_ready_i,
    output logic                   id_valid_o,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic                   id_prdt_taken_o,
    output logic                   id_pc_misalign_o,
    output logic                   id_bus_err_o,
    output logic                   fq_halt_o
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = PC_WIDTH + INSTR_WIDTH + 3;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FQ_DEPTH);

    typedef enum logic [0:0] {
        C_ST_RUN  = 1'b0,
        C_ST_HALT = 1'b1
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [PC_WIDTH-1:0] r_pc_q,    w_pc_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic [PTR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [ENT_W-1:0]   r_mem_q [FQ_DEPTH];
    logic [ENT_W-1:0]   w_mem_d [FQ_DEPTH];

    logic               w_id_fire;
    logic               w_fetch_fire;
    logic               w_fault;
    logic [ENT_W-1:0]   w_head;

    assign w_id_fire    = (r_cnt_q != '0) & id_ready_i;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign w_fetch_fire = (r_state_q == C_ST_RUN) & ~flush_i
                        & ((r_cnt_q != C_FULL) | w_id_fire);
    assign w_fault      = ifu_pc_misalign_i | ifu_bus_err_i;

    always_comb begin
        w_state_d  = r_state_q;
        w_pc_d     = r_pc_q;
        w_cnt_d    = r_cnt_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_mem_d    = r_mem_q;
        if (flush_i) begin
            w_state_d  = C_ST_RUN;
            w_pc_d     = flush_pc_i;
            w_cnt_d    = '0;
            w_rd_ptr_d = '0;
            w_wr_ptr_d = '0;
        end else begin
            if (w_fetch_fire) begin
                w_mem_d[r_wr_ptr_q] = {r_pc_q, ifu_instr_i, ifu_prdt_taken_i,
                                       ifu_pc_misalign_i, ifu_bus_err_i};
                w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
                w_pc_d     = ifu_pc_next_i;
                if (w_fault) begin
                    w_state_d = C_ST_HALT;
                end
            end
            if (w_id_fire) begin
                w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
            end
            case ({w_fetch_fire, w_id_fire})
                2'b10:   w_cnt_d = r_cnt_q + CNT_W'(1);
                2'b01:   w_cnt_d = r_cnt_q - CNT_W'(1);
                default: w_cnt_d = r_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q  <= C_ST_RUN;
            r_pc_q     <= RESET_PC;
            r_cnt_q    <= '0;
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_cnt_q    <= w_cnt_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_mem_q    <= w_mem_d;
        end
    end

    // ID sees only registered storage, never the live ifu inputs.
    assign w_head           = r_mem_q[r_rd_ptr_q];
    assign IF_pc_o          = r_pc_q;
    assign id_valid_o       = (r_cnt_q != '0);
    assign id_pc_o          = w_head[ENT_W-1 -: PC_WIDTH];
    assign id_instr_o       = w_head[INSTR_WIDTH+2 : 3];
    assign id_prdt_taken_o  = w_head[2];
    assign id_pc_misalign_o = w_head[1];
    assign id_bus_err_o     = w_head[0];
    assign fq_halt_o        = (r_state_q == C_ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Self-checking bench for if_fetch_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_queue;

    localparam int          FQ_DEPTH = 2;
    localparam logic [63:0] C_BASE   = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        prdt;
        logic        mis;
        logic        berr;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [63:0] IF_pc_o;
    logic [63:0] ifu_pc_next_i = '0;
    logic [31:0] ifu_instr_i = '0;
    logic        ifu_prdt_taken_i = 1'b0;
    logic        ifu_pc_misalign_i = 1'b0;
    logic        ifu_bus_err_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [63:0] flush_pc_i = '0;
    logic        id_ready_i = 1'b0;
    logic        id_valid_o;
    logic [63:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_prdt_taken_o;
    logic        id_pc_misalign_o;
    logic        id_bus_err_o;
    logic        fq_halt_o;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    logic [63:0] m_pc;
    logic        m_halt;

    if_fetch_queue #(
        .PC_WIDTH   (64),
        .INSTR_WIDTH(32),
        .RESET_PC   (C_BASE),
        .FQ_DEPTH   (FQ_DEPTH)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .IF_pc_o          (IF_pc_o),
        .ifu_pc_next_i    (ifu_pc_next_i),
        .ifu_instr_i      (ifu_instr_i),
        .ifu_prdt_taken_i (ifu_prdt_taken_i),
        .ifu_pc_misalign_i(ifu_pc_misalign_i),
        .ifu_bus_err_i    (ifu_bus_err_i),
        .flush_i          (flush_i),
        .flush_pc_i       (flush_pc_i),
        .id_ready_i       (id_ready_i),
        .id_valid_o       (id_valid_o),
        .id_pc_o          (id_pc_o),
        .id_instr_o       (id_instr_o),
        .id_prdt_taken_o  (id_prdt_taken_o),
        .id_pc_misalign_o (id_pc_misalign_o),
        .id_bus_err_o     (id_bus_err_o),
        .fq_halt_o        (fq_halt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance the reference by one clock using the current inputs, then step
    // the DUT and return at the falling edge where outputs are compared.
    task automatic tick();
        bit   v, idf, ff;
        ent_t e;
        v   = (mq.size() != 0);
        idf = v && id_ready_i;
        ff  = !m_halt && !flush_i && ((mq.size() != FQ_DEPTH) || idf);
        e   = '{pc: m_pc, instr: ifu_instr_i, prdt: ifu_prdt_taken_i,
                mis: ifu_pc_misalign_i, berr: ifu_bus_err_i};
        if (rst_i) begin
            mq.delete();
            m_pc   = C_BASE;
            m_halt = 1'b0;
        end else if (flush_i) begin
            mq.delete();
            m_pc   = flush_pc_i;
            m_halt = 1'b0;
        end else begin
            if (idf) void'(mq.pop_front());
            if (ff) begin
                mq.push_back(e);
                m_pc = ifu_pc_next_i;
                if (ifu_pc_misalign_i || ifu_bus_err_i) m_halt = 1'b1;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        ifu_instr_i       = '0;
        ifu_prdt_taken_i  = 1'b0;
        ifu_pc_misalign_i = 1'b0;
        ifu_bus_err_i     = 1'b0;
        flush_i           = 1'b0;
        id_ready_i        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({IF_pc_o, id_valid_o, fq_halt_o} !== {C_BASE, 2'b00}) begin
            errors++;
            $display("FAIL reset_ctrl: got pc=%h v=%b h=%b, want pc=%h v=0 h=0",
                     IF_pc_o, id_valid_o, fq_halt_o, C_BASE);
        end
        checks++;
        if ({id_pc_o, id_instr_o, id_prdt_taken_o, id_pc_misalign_o, id_bus_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_head: got pc=%h instr=%h flags=%b%b%b, want all 0",
                     id_pc_o, id_instr_o, id_prdt_taken_o, id_pc_misalign_o, id_bus_err_o);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] instrs [4];
        do_reset();
        id_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instrs[i]     = $urandom;
            ifu_instr_i   = instrs[i];
            ifu_pc_next_i = m_pc + 64'd4;
            tick();
            checks++;
            if ({IF_pc_o, id_valid_o, id_pc_o, id_instr_o} !==
                {C_BASE + 64'(4 * (i + 1)), 1'b1, C_BASE + 64'(4 * i), instrs[i]}) begin
                errors++;
                $display("FAIL seq_%0d: got pc=%h v=%b idpc=%h ins=%h, want pc=%h v=1 idpc=%h ins=%h",
                         i, IF_pc_o, id_valid_o, id_pc_o, id_instr_o,
                         C_BASE + 64'(4 * (i + 1)), C_BASE + 64'(4 * i), instrs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ifu_pc_next_i = m_pc + 64'd4;
            tick();
        end
        checks++;
        if ({IF_pc_o, id_valid_o, id_pc_o} !== {C_BASE + 64'd8, 1'b1, C_BASE}) begin
            errors++;
            $display("FAIL bp_full: got pc=%h v=%b idpc=%h, want pc=%h v=1 idpc=%h",
                     IF_pc_o, id_valid_o, id_pc_o, C_BASE + 64'd8, C_BASE);
        end
        id_ready_i = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            ifu_pc_next_i = m_pc + 64'd4;
            tick();
            checks++;
            if ({IF_pc_o, id_valid_o, id_pc_o} !==
                {C_BASE + 64'(8 + 4 * i), 1'b1, C_BASE + 64'(4 * i)}) begin
                errors++;
                $display("FAIL bp_drain_%0d: got pc=%h v=%b idpc=%h, want pc=%h v=1 idpc=%h",
                         i, IF_pc_o, id_valid_o, id_pc_o,
                         C_BASE + 64'(8 + 4 * i), C_BASE + 64'(4 * i));
            end
        end
    endtask

    task automatic test_flush_full();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ifu_pc_next_i = m_pc + 64'd4;
            tick();
        end
        flush_i    = 1'b1;
        flush_pc_i = 64'h0000_0000_8000_1000;
        tick();
        flush_i = 1'b0;
        checks++;
        if ({IF_pc_o, id_valid_o} !== {64'h0000_0000_8000_1000, 1'b0}) begin
            errors++;
            $display("FAIL flush_next: got pc=%h v=%b, want pc=0000000080001000 v=0",
                     IF_pc_o, id_valid_o);
        end
        ifu_pc_next_i = m_pc + 64'd4;
        tick();
        checks++;
        if ({IF_pc_o, id_valid_o, id_pc_o} !==
            {64'h0000_0000_8000_1004, 1'b1, 64'h0000_0000_8000_1000}) begin
            errors++;
            $display("FAIL flush_refill: got pc=%h v=%b idpc=%h, want pc=80001004 v=1 idpc=80001000",
                     IF_pc_o, id_valid_o, id_pc_o);
        end
    endtask

    task automatic test_bus_err();
        do_reset();
        id_ready_i = 1'b1;
        for (int i = 0; i < 8 && !m_halt; i++) begin
            ifu_pc_next_i = m_pc + 64'd4;
            ifu_bus_err_i = (m_pc == C_BASE + 64'd16);
            tick();
        end
        ifu_bus_err_i = 1'b0;
        checks++;
        if ({fq_halt_o, id_valid_o, id_pc_o, id_bus_err_o, IF_pc_o} !==
            {2'b11, C_BASE + 64'd16, 1'b1, C_BASE + 64'd20}) begin
            errors++;
            $display("FAIL berr_entry: got h=%b v=%b idpc=%h be=%b pc=%h, want h=1 v=1 idpc=%h be=1 pc=%h",
                     fq_halt_o, id_valid_o, id_pc_o, id_bus_err_o, IF_pc_o,
                     C_BASE + 64'd16, C_BASE + 64'd20);
        end
        for (int i = 0; i < 3; i++) begin
            ifu_pc_next_i = m_pc + 64'd4;
            tick();
        end
        checks++;
        if ({fq_halt_o, id_valid_o, IF_pc_o} !== {2'b10, C_BASE + 64'd20}) begin
            errors++;
            $display("FAIL berr_drained: got h=%b v=%b pc=%h, want h=1 v=0 pc=%h",
                     fq_halt_o, id_valid_o, IF_pc_o, C_BASE + 64'd20);
        end
        flush_i    = 1'b1;
        flush_pc_i = 64'h0000_0000_8000_0200;
        tick();
        flush_i = 1'b0;
        checks++;
        if ({fq_halt_o, id_valid_o, IF_pc_o} !== {2'b00, 64'h0000_0000_8000_0200}) begin
            errors++;
            $display("FAIL berr_flush: got h=%b v=%b pc=%h, want h=0 v=0 pc=80000200",
                     fq_halt_o, id_valid_o, IF_pc_o);
        end
    endtask

    task automatic test_prdt();
        do_reset();
        ifu_prdt_taken_i = 1'b1;
        ifu_pc_next_i    = C_BASE - 64'd8;
        tick();
        ifu_prdt_taken_i = 1'b0;
        checks++;
        if ({IF_pc_o, id_valid_o, id_pc_o, id_prdt_taken_o} !==
            {64'h0000_0000_7FFF_FFF8, 1'b1, C_BASE, 1'b1}) begin
            errors++;
            $display("FAIL prdt: got pc=%h v=%b idpc=%h pt=%b, want pc=7ffffff8 v=1 idpc=%h pt=1",
                     IF_pc_o, id_valid_o, id_pc_o, id_prdt_taken_o, C_BASE);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ifu_pc_next_i = m_pc + 64'd4;
        tick();
        ifu_pc_misalign_i = 1'b1;
        ifu_pc_next_i     = m_pc + 64'd4;
        tick();
        ifu_pc_misalign_i = 1'b0;
        checks++;
        if ({fq_halt_o, id_valid_o, id_pc_o} !== {2'b11, C_BASE}) begin
            errors++;
            $display("FAIL rstmid_pre: got h=%b v=%b idpc=%h, want h=1 v=1 idpc=%h",
                     fq_halt_o, id_valid_o, id_pc_o, C_BASE);
        end
        do_reset();
        checks++;
        if ({IF_pc_o, id_valid_o, fq_halt_o, id_pc_o, id_pc_misalign_o} !==
            {C_BASE, 2'b00, 64'd0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_post: got pc=%h v=%b h=%b idpc=%h mis=%b, want pc=%h v=0 h=0 idpc=0 mis=0",
                     IF_pc_o, id_valid_o, fq_halt_o, id_pc_o, id_pc_misalign_o, C_BASE);
        end
    endtask

    task automatic test_random();
        ent_t got;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            rst_i             = ($urandom_range(0, 99) == 0);
            flush_i           = ($urandom_range(0, 19) == 0);
            flush_pc_i        = {$urandom, $urandom};
            id_ready_i        = ($urandom_range(0, 2) != 0);
            ifu_instr_i       = $urandom;
            ifu_prdt_taken_i  = $urandom_range(0, 1);
            ifu_pc_misalign_i = ($urandom_range(0, 39) == 0);
            ifu_bus_err_i     = ($urandom_range(0, 39) == 0);
            ifu_pc_next_i     = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                            : m_pc + 64'd4;
            tick();
            checks++;
            if ({IF_pc_o, id_valid_o, fq_halt_o} !== {m_pc, mq.size() != 0, m_halt}) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: got pc=%h v=%b h=%b, want pc=%h v=%b h=%b",
                         n, IF_pc_o, id_valid_o, fq_halt_o, m_pc, mq.size() != 0, m_halt);
            end
            if (mq.size() != 0) begin
                got = '{pc: id_pc_o, instr: id_instr_o, prdt: id_prdt_taken_o,
                        mis: id_pc_misalign_o, berr: id_bus_err_o};
                checks++;
                if (got !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_head@%0d: got %h, want %h", n, got, mq[0]);
                end
            end
        end
        rst_i = 1'b0;
        idle_inputs();
    endtask

    initial begin
        m_pc   = C_BASE;
        m_halt = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_sequential();
        test_backpressure();
        test_flush_full();
        test_bus_err();
        test_prdt();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Fetch-stage sequential shell around the combinational ifu.
- Owns the IF PC register and drives IF_pc into ifu.
- Captures ifu's fetched instruction, predicted-taken bit and fetch exceptions into a small in-order fetch queue.
- Presents the queue head to the ID stage over a valid/ready handshake; handles redirect flush and halts fetch after a faulting fetch.

Parameters:
- PC_WIDTH, 64: PC width; equals XLEN.
- INSTR_WIDTH, 32: instruction width.
- RESET_PC, 64'h0000_0000_8000_0000: PC value after reset.
- FQ_DEPTH, 2: queue entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- IF_pc_o  out  PC_WIDTH  current fetch PC, to ifu IF_pc_i.
- ifu_pc_next_i  in  PC_WIDTH  next PC computed by ifu.
- ifu_instr_i  in  INSTR_WIDTH  instruction fetched at IF_pc_o.
- ifu_prdt_taken_i  in  1  static branch prediction bit.
- ifu_pc_misalign_i  in  1  fetch address misaligned.
- ifu_bus_err_i  in  1  fetch bus error.
- flush_i  in  1  redirect from EX/commit.
- flush_pc_i  in  PC_WIDTH  redirect target.
- id_ready_i  in  1  ID can accept the head entry this cycle.
- id_valid_o  out  1  head entry valid.
- id_pc_o  out  PC_WIDTH  head entry PC.
- id_instr_o  out  INSTR_WIDTH  head entry instruction.
- id_prdt_taken_o  out  1  head entry prediction bit.
- id_pc_misalign_o  out  1  head entry misalign exception.
- id_bus_err_o  out  1  head entry bus-error exception.
- fq_halt_o  out  1  fetch halted after an exception.

Behaviour:
- Single clock clk_i; rst_i is synchronous and active-high.
- Reset values: PC = RESET_PC; queue empty (cnt = 0, rd_ptr = 0, wr_ptr = 0); state RUN; all queue storage 0.
  - Hence id_valid_o = 0, all id_*_o = 0, fq_halt_o = 0.
  - rst_i asserted mid-operation discards all in-flight entries and restores these values on the next edge.
- Definitions:
  - id_fire = id_valid_o & id_ready_i.
  - fetch_fire = (state == RUN) & ~flush_i & ((cnt != FQ_DEPTH) | id_fire).
  - Enqueue while full is therefore allowed only when a dequeue occurs in the same cycle.
- On fetch_fire:
  - Write {IF_pc_o, ifu_instr_i, ifu_prdt_taken_i, ifu_pc_misalign_i, ifu_bus_err_i} at wr_ptr.
  - PC <= ifu_pc_next_i.
  - If ifu_pc_misalign_i | ifu_bus_err_i, state <= HALT.
- When not fetch_fire and not flush, PC holds.
- Count update: cnt += fetch_fire - id_fire; both fire -> cnt unchanged.
- Pointers wrap modulo FQ_DEPTH.
- id_valid_o = (cnt != 0).
- id_*_o come from registered storage at rd_ptr; no combinational path from ifu_* to id_*_o.
- Latency: an entry fetched in cycle N is visible on id_*_o in cycle N+1 when the queue was empty. Throughput is 1 instruction/cycle.
- Handshake: a head entry with id_valid_o = 1 stays stable (all id_*_o fields) until id_fire or flush.
- State machine (2 states):
  - RUN: fetch enabled.
  - HALT: fetch disabled; PC holds; fq_halt_o = 1; the queue keeps draining to ID.
  - Transitions: RUN -> HALT on fetch_fire of a faulting fetch. HALT -> RUN only on flush_i.
- flush_i has priority over everything except rst_i. Next cycle:
  - PC = flush_pc_i.
  - Queue empty, pointers 0, state RUN.
  - No enqueue in the flush cycle.
  - An id_fire in the flush cycle does not change the post-flush state; ID discards its own copy on flush.
- Misaligned flush_pc_i is accepted unchanged; ifu reports the misalign on the next fetch.

Test Plan:
- Reset, id_ready_i = 1, ifu_pc_next_i = IF_pc_o + 4 -> IF_pc_o = 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; id_pc_o trails by one cycle; id_valid_o stays high.
- id_ready_i = 0 for 4 cycles from empty:
  - Exactly 2 entries are accepted (0x8000_0000, 0x8000_0004), then IF_pc_o holds at 0x8000_0008.
  - Raising id_ready_i delivers 0x8000_0000 then 0x8000_0004 in order with no loss.
  - A new enqueue occurs in the same cycle as the first dequeue.
- Queue full, flush_i = 1, flush_pc_i = 0x8000_1000, id_ready_i = 0 -> next cycle id_valid_o = 0 and IF_pc_o = 0x8000_1000; the cycle after, id_pc_o = 0x8000_1000.
- ifu_bus_err_i = 1 at PC 0x8000_0010 -> that entry is enqueued with id_bus_err_o = 1; fq_halt_o = 1 next cycle; IF_pc_o frozen; no further enqueues; the queue drains; flush to 0x8000_0200 clears the halt.
- Static prediction passthrough: ifu_prdt_taken_i = 1 with ifu_pc_next_i = 0x8000_0000 - 8 -> next IF_pc_o = 0x7FFF_FFF8; id_prdt_taken_o = 1 for that entry.
- rst_i asserted while 2 entries are queued and state is HALT -> next cycle id_valid_o = 0, fq_halt_o = 0, IF_pc_o = 0x8000_0000.
